// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states
// and the R/W and ACK/NACK bus bit values.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_BYTE,
    S_WR_ACK,
    S_RD_BYTE,
    S_RD_ACK,
    S_WAIT_STOP
  } i2c_state_t;

  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic ACK          = 1'b0;
  localparam logic NACK         = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser with one-cycle edge, START and STOP events.
// Ports: clk, rst (sync, active-high), scl/sda pins in;
// sda_s (synchronised SDA), scl_rise, scl_fall, start, stop out.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_q;
  logic [SYNC_STAGES-1:0] sda_q;
  logic scl_p;
  logic sda_p;
  logic scl_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= '1;
      sda_q <= '1;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_q <= {scl_q[SYNC_STAGES-2:0], scl};
      sda_q <= {sda_q[SYNC_STAGES-2:0], sda};
      scl_p <= scl_q[SYNC_STAGES-1];
      sda_p <= sda_q[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_q[SYNC_STAGES-1];
  assign sda_s    = sda_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  // SDA may only move under a stable high SCL for START/STOP
  assign start = scl_s & scl_p & sda_p & ~sda_s;
  assign stop  = scl_s & scl_p & ~sda_p & sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target with 7-bit address, open-drain SDA, no clock stretching.
// Ports: clk, rst, i2c_scl, i2c_sda (0/z), tx_data/tx_req (read bytes),
// rx_data/rx_valid (written bytes), busy, rw.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       rw
);

  i2c_state_t state;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start;
  logic       stop;
  logic       sda_oe;
  logic [2:0] bit_cnt;
  logic       got8;
  logic [7:0] sh;
  logic [7:0] tx_sh;
  logic       in_byte;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl      (i2c_scl),
    .sda      (i2c_sda),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

  assign in_byte = (state == S_ADDR) ||
                   (state == S_WR_BYTE) ||
                   (state == S_RD_BYTE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      rw       <= I2C_RW_WRITE;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      sh       <= 8'h00;
      tx_sh    <= 8'h00;
      bit_cnt  <= 3'd0;
      got8     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (tx_req)
        tx_sh <= tx_data;
      if (stop) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start) begin
        state   <= S_ADDR;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= 3'd0;
        got8    <= 1'b0;
      end else begin
        if (scl_rise && in_byte) begin
          bit_cnt <= bit_cnt + 3'd1;
          sh      <= {sh[6:0], sda_s};
          if (bit_cnt == 3'd7)
            got8 <= 1'b1;
        end
        unique case (state)
          S_ADDR: begin
            if (scl_fall && got8) begin
              if (sh[7:1] == SLAVE_ADDR) begin
                state  <= S_ADDR_ACK;
                rw     <= sh[0];
                busy   <= 1'b1;
                sda_oe <= 1'b1;
                tx_req <= (sh[0] == I2C_RW_READ);
              end else begin
                state  <= S_WAIT_STOP;
                sda_oe <= 1'b0;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 3'd0;
              got8    <= 1'b0;
              if (rw == I2C_RW_READ) begin
                state  <= S_RD_BYTE;
                sda_oe <= ~tx_sh[7];
                tx_sh  <= {tx_sh[6:0], 1'b0};
              end else begin
                state  <= S_WR_BYTE;
                sda_oe <= 1'b0;
              end
            end
          end
          S_WR_BYTE: begin
            if (scl_fall && got8) begin
              rx_data  <= sh;
              rx_valid <= 1'b1;
              state    <= S_WR_ACK;
              sda_oe   <= 1'b1;
            end
          end
          S_WR_ACK: begin
            if (scl_fall) begin
              state   <= S_WR_BYTE;
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd0;
              got8    <= 1'b0;
            end
          end
          S_RD_BYTE: begin
            if (scl_fall) begin
              if (got8) begin
                state  <= S_RD_ACK;
                sda_oe <= 1'b0;
              end else begin
                sda_oe <= ~tx_sh[7];
                tx_sh  <= {tx_sh[6:0], 1'b0};
              end
            end
          end
          S_RD_ACK: begin
            // NACK leaves at the rise; a fall here means ACK was seen
            if (scl_rise) begin
              if (sda_s == ACK)
                tx_req <= 1'b1;
              else
                state <= S_WAIT_STOP;
            end else if (scl_fall) begin
              state   <= S_RD_BYTE;
              sda_oe  <= ~tx_sh[7];
              tx_sh   <= {tx_sh[6:0], 1'b0};
              bit_cnt <= 3'd0;
              got8    <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Scoreboard bench for i2c_target: a bus-master driver
// issues transfers, a monitor checks rx_valid/tx_req pulses.
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  wire        sda;
  logic [7:0] tx_data = 8'hFF;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       rw;

  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_target #(
    .SLAVE_ADDR  (7'h50),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i2c_scl  (scl),
    .i2c_sda  (sda),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .rw       (rw)
  );

  typedef struct packed {
    logic       is_tx;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] tx_src[$];
  ev_t        got_ev;
  ev_t        exp_ev;
  logic       pop_pend = 1'b0;
  int         vec = 0;
  int         err = 0;

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] req);
    vec++;
    if (act !== req) begin
      err++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic exp_rx(input logic [7:0] d);
    exp_q.push_back({1'b0, d});
  endtask

  task automatic exp_tx();
    exp_q.push_back({1'b1, 8'h00});
  endtask

  task automatic tx_push(input logic [7:0] d);
    tx_src.push_back(d);
    tx_data = tx_src[0];
  endtask

  // Monitor: pops the expected pulse whenever the DUT pulses
  always @(negedge clk) begin
    if (pop_pend) begin
      pop_pend = 1'b0;
      if (tx_src.size() > 0)
        tx_src.delete(0);
      tx_data = (tx_src.size() > 0) ? tx_src[0] : 8'hFF;
    end
    if (tx_req === 1'b1)
      pop_pend = 1'b1;
    if (rx_valid === 1'b1 || tx_req === 1'b1) begin
      got_ev.is_tx = tx_req;
      got_ev.data  = tx_req ? 8'h00 : rx_data;
      if (exp_q.size() == 0) begin
        vec++;
        err++;
        $display("FAIL unexpected pulse: got %h, want none",
                 got_ev);
      end else begin
        exp_ev = exp_q.pop_front();
        check("pulse", {7'd0, got_ev}, {7'd0, exp_ev});
      end
    end
  end

  // Quarter SCL period: 5 clk, so SCL runs at clk/20
  task automatic q();
    repeat (5) @(negedge clk);
  endtask

  task automatic m_start();
    m_sda = 1'b1; q();
    scl = 1'b1;   q();
    m_sda = 1'b0; q();
    scl = 1'b0;   q();
  endtask

  task automatic m_stop();
    m_sda = 1'b0; q();
    scl = 1'b1;   q();
    m_sda = 1'b1; q();
    q();
  endtask

  task automatic m_bit(input logic b, output logic r);
    m_sda = b;  q();
    scl = 1'b1; q();
    r = sda;    q();
    scl = 1'b0; q();
  endtask

  task automatic wr_byte(input string name,
                         input logic [7:0] d,
                         input logic exp_ack);
    logic r;
    for (int i = 7; i >= 0; i--)
      m_bit(d[i], r);
    m_bit(1'b1, r);
    check(name, r, exp_ack);
  endtask

  task automatic rd_byte(input string name,
                         input logic [7:0] exp,
                         input logic send_ack);
    logic       r;
    logic [7:0] got;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, r);
      got[i] = r;
    end
    check(name, got, exp);
    m_bit(send_ack, r);
  endtask

  initial begin
    logic r;
    repeat (3) @(negedge clk);
    check("reset tx_req", tx_req, 0);
    check("reset rx_valid", rx_valid, 0);
    check("reset busy", busy, 0);
    check("reset rw", rw, 0);
    check("reset rx_data", rx_data, 8'h00);
    check("reset sda", sda, 1);
    rst = 1'b0;
    q();

    // write A5, 3C to 0x50
    exp_rx(8'hA5);
    exp_rx(8'h3C);
    m_start();
    wr_byte("wr addr ack", 8'hA0, 1'b0);
    check("wr busy", busy, 1);
    check("wr rw", rw, 0);
    wr_byte("wr A5 ack", 8'hA5, 1'b0);
    wr_byte("wr 3C ack", 8'h3C, 1'b0);
    check("wr rx_data", rx_data, 8'h3C);
    m_stop();
    check("wr busy after stop", busy, 0);
    check("wr sda after stop", sda, 1);

    // wrong address 0x51
    m_start();
    wr_byte("bad addr nack", 8'hA2, 1'b1);
    check("bad addr busy", busy, 0);
    wr_byte("bad addr data nack", 8'h55, 1'b1);
    m_stop();
    check("bad addr busy stop", busy, 0);

    // read C3, 5A from 0x50; ACK then NACK
    tx_push(8'hC3);
    tx_push(8'h5A);
    exp_tx();
    exp_tx();
    m_start();
    wr_byte("rd addr ack", 8'hA1, 1'b0);
    check("rd busy", busy, 1);
    check("rd rw", rw, 1);
    rd_byte("rd C3", 8'hC3, 1'b0);
    rd_byte("rd 5A", 8'h5A, 1'b1);
    check("rd busy after nack", busy, 1);
    check("rd sda after nack", sda, 1);
    m_stop();
    check("rd busy after stop", busy, 0);

    // write 12, repeated START, read 0x50
    exp_rx(8'h12);
    exp_tx();
    tx_push(8'h99);
    m_start();
    wr_byte("rs wr addr ack", 8'hA0, 1'b0);
    wr_byte("rs wr 12 ack", 8'h12, 1'b0);
    m_start();
    check("rs busy cleared", busy, 0);
    wr_byte("rs rd addr ack", 8'hA1, 1'b0);
    check("rs rw", rw, 1);
    check("rs busy", busy, 1);
    rd_byte("rs rd 99", 8'h99, 1'b1);
    m_stop();

    // STOP after 4 bits of a write byte
    m_start();
    wr_byte("part addr ack", 8'hA0, 1'b0);
    m_bit(1'b1, r);
    m_bit(1'b0, r);
    m_bit(1'b1, r);
    m_bit(1'b1, r);
    m_stop();
    check("part busy", busy, 0);
    check("part sda", sda, 1);
    check("part rx_data kept", rx_data, 8'h12);

    // reset while SDA is driven low in RD_BYTE
    tx_push(8'h00);
    exp_tx();
    m_start();
    wr_byte("rst addr ack", 8'hA1, 1'b0);
    check("rst sda driven", sda, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst sda released", sda, 1);
    check("rst busy", busy, 0);
    check("rst rw", rw, 0);
    check("rst rx_data", rx_data, 8'h00);
    check("rst tx_req", tx_req, 0);
    check("rst rx_valid", rx_valid, 0);
    rst = 1'b0;
    q();
    m_stop();

    // normal write after reset
    exp_rx(8'h77);
    m_start();
    wr_byte("post addr ack", 8'hA0, 1'b0);
    wr_byte("post 77 ack", 8'h77, 1'b0);
    m_stop();
    check("post busy", busy, 0);
    check("post rx_data", rx_data, 8'h77);

    repeat (20) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
